// File: rtl/lif_spike_aer_tx.sv
// Spike-vector to AER serializer: one event per set bit, lowest index first, then an EOT beat.
// Optional AER_TIMESTAMP_EN adds aer_ts_o carrying the accepted-tick count.
module lif_spike_aer_tx #(
  parameter int NUM_NEURONS = 254,
  parameter int ADDR_W      = 8,
  parameter int DROP_CNT_W  = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   tick_i,
  input  logic [NUM_NEURONS-1:0] spikes_i,
  output logic                   aer_valid_o,
  input  logic                   aer_ready_i,
  output logic [ADDR_W-1:0]      aer_addr_o,
  output logic                   aer_eot_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   overflow_o,
  output logic [DROP_CNT_W-1:0]  drop_cnt_o
`ifdef AER_TIMESTAMP_EN
  ,
  output logic [15:0]            aer_ts_o
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    EMIT,
    EOT
  } state_e;

  state_e state_q, state_d;

  logic [NUM_NEURONS-1:0] pend_q, pend_d, pend_rest;
  logic                   valid_q, valid_d;
  logic                   eot_q, eot_d;
  logic                   done_q, done_d;
  logic                   busy_q, busy_d;
  logic                   ovf_q, ovf_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [DROP_CNT_W-1:0]  drop_q, drop_d;
  logic                   hs;
  logic                   drop;

`ifdef AER_TIMESTAMP_EN
  logic [15:0] tcnt_q, tcnt_d;
  logic [15:0] ts_q, ts_d;
`endif

  function automatic logic [ADDR_W-1:0] lowest(
    input logic [NUM_NEURONS-1:0] v
  );
    lowest = '0;
    for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
      if (v[i]) lowest = ADDR_W'(i);
    end
  endfunction

  assign hs        = valid_q & aer_ready_i;
  assign drop      = tick_i & (state_q != IDLE);
  // Clearing the lowest set bit removes exactly the beat just accepted.
  assign pend_rest = pend_q & (pend_q - NUM_NEURONS'(1));

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    valid_d = valid_q;
    eot_d   = eot_q;
    addr_d  = addr_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q | drop;
    drop_d  = drop_q;
    if (drop && (drop_q != '1)) begin
      drop_d = drop_q + DROP_CNT_W'(1);
    end
`ifdef AER_TIMESTAMP_EN
    tcnt_d = tcnt_q;
    ts_d   = ts_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (tick_i) begin
          pend_d  = spikes_i;
          state_d = LOAD;
`ifdef AER_TIMESTAMP_EN
          tcnt_d  = tcnt_q + 16'd1;
`endif
        end
      end
      LOAD: begin
        valid_d = 1'b1;
`ifdef AER_TIMESTAMP_EN
        ts_d    = tcnt_q;
`endif
        if (|pend_q) begin
          addr_d  = lowest(pend_q);
          state_d = EMIT;
        end else begin
          eot_d   = 1'b1;
          addr_d  = '0;
          state_d = EOT;
        end
      end
      EMIT: begin
        if (hs) begin
          pend_d = pend_rest;
          if (|pend_rest) begin
            addr_d = lowest(pend_rest);
          end else begin
            eot_d   = 1'b1;
            addr_d  = '0;
            state_d = EOT;
          end
        end
      end
      EOT: begin
        if (hs) begin
          valid_d = 1'b0;
          eot_d   = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      pend_q  <= '0;
      valid_q <= 1'b0;
      eot_q   <= 1'b0;
      addr_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
`ifdef AER_TIMESTAMP_EN
      tcnt_q  <= '0;
      ts_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      valid_q <= valid_d;
      eot_q   <= eot_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
`ifdef AER_TIMESTAMP_EN
      tcnt_q  <= tcnt_d;
      ts_q    <= ts_d;
`endif
    end
  end

  assign aer_valid_o = valid_q;
  assign aer_addr_o  = addr_q;
  assign aer_eot_o   = eot_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign overflow_o  = ovf_q;
  assign drop_cnt_o  = drop_q;
`ifdef AER_TIMESTAMP_EN
  assign aer_ts_o    = ts_q;
`endif

endmodule

// File: tb/tb_lif_spike_aer_tx.sv
// Randomized bench for lif_spike_aer_tx against a queue-based beat model.
// Define AER_TIMESTAMP_EN to also check aer_ts_o.
module tb_lif_spike_aer_tx;
  localparam int NN = 254;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tick = 1'b0;
  logic          rdy = 1'b0;
  logic [NN-1:0] spikes = '0;
  logic          vld, eot, busy, done, ovf;
  logic [7:0]    addr;
  logic [15:0]   dcnt;
`ifdef AER_TIMESTAMP_EN
  logic [15:0]   ts;
  logic [15:0]   exp_ts = '0;
`endif

  int          n_chk = 0;
  int          n_ok = 0;
  logic [15:0] drops = '0;

  lif_spike_aer_tx dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .tick_i     (tick),
    .spikes_i   (spikes),
    .aer_valid_o(vld),
    .aer_ready_i(rdy),
    .aer_addr_o (addr),
    .aer_eot_o  (eot),
    .busy_o     (busy),
    .done_o     (done),
    .overflow_o (ovf),
    .drop_cnt_o (dcnt)
`ifdef AER_TIMESTAMP_EN
    ,
    .aer_ts_o   (ts)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [NN-1:0] rnd_vec(input int pct);
    logic [NN-1:0] v;
    for (int i = 0; i < NN; i++) v[i] = ($urandom_range(99) < pct);
    return v;
  endfunction

  // One tick: expected beats are the set indices ascending, then EOT (-1).
  task automatic run_tick(
    input logic [NN-1:0] sp, input int rdy_pct, input int stall,
    input int tick_at, input int tkp, input bit lat,
    input bit chain, input logic [NN-1:0] nsp, input bit pre
  );
    int q[$];
    int k, x;
    logic [7:0] wa;
    for (int i = 0; i < NN; i++) if (sp[i]) q.push_back(i);
    k = q.size();
    q.push_back(-1);
    if (!pre) begin
      @(negedge clk);
      tick = 1'b1; spikes = sp; rdy = 1'b0;
    end
    @(negedge clk);
`ifdef AER_TIMESTAMP_EN
    exp_ts = exp_ts + 16'd1;
`endif
    for (int e = 0; e < 3000 && q.size() > 0; e++) begin
      if (e > 0) @(negedge clk);
      tick = 1'b0;
      spikes = rnd_vec(50);
      if ((e == tick_at) || ($urandom_range(99) < tkp)) begin
        tick = 1'b1;
        if (drops != 16'hFFFF) drops = drops + 16'd1;
      end
      if (e <= stall) rdy = 1'b0;
      else rdy = ($urandom_range(99) < rdy_pct);
      n_chk++;
      if (busy !== 1'b1) $display("FAIL busy_mid e=%0d got %b want 1", e, busy);
      else n_ok++;
      if (e == 0) begin
        n_chk++;
        if (vld !== 1'b0 || done !== 1'b0)
          $display("FAIL load_cycle valid=%b done=%b want 0 0", vld, done);
        else n_ok++;
      end else begin
        x = q[0];
        wa = (x < 0) ? 8'd0 : 8'(x);
        n_chk++;
        if (vld !== 1'b1) $display("FAIL valid e=%0d got %b want 1", e, vld);
        else n_ok++;
        n_chk++;
        if (addr !== wa || eot !== (x < 0))
          $display("FAIL beat e=%0d addr=%0d eot=%b want addr=%0d eot=%b",
                   e, addr, eot, wa, (x < 0));
        else n_ok++;
`ifdef AER_TIMESTAMP_EN
        n_chk++;
        if (ts !== exp_ts) $display("FAIL ts got %0d want %0d", ts, exp_ts);
        else n_ok++;
`endif
        if (vld === 1'b1 && rdy) begin
          void'(q.pop_front());
          if (x < 0 && lat) begin
            n_chk++;
            if (e + 1 != 2 + k)
              $display("FAIL eot_latency edge=%0d want %0d", e + 1, 2 + k);
            else n_ok++;
          end
        end
      end
    end
    if (q.size() != 0) begin
      n_chk++;
      $display("FAIL timeout beats_left=%0d want 0", q.size());
      return;
    end
    @(negedge clk);
    tick = 1'b0;
    rdy = 1'b0;
    n_chk++;
    if (done !== 1'b1 || busy !== 1'b0 || vld !== 1'b0 || eot !== 1'b0)
      $display("FAIL done_pulse done=%b busy=%b valid=%b eot=%b want 1 0 0 0",
               done, busy, vld, eot);
    else n_ok++;
    n_chk++;
    if (ovf !== (drops != 0) || dcnt !== drops)
      $display("FAIL drops ovf=%b cnt=%0d want %b %0d", ovf, dcnt, (drops != 0), drops);
    else n_ok++;
    if (chain) begin
      tick = 1'b1;
      spikes = nsp;
    end else begin
      @(negedge clk);
      n_chk++;
      if (done !== 1'b0 || vld !== 1'b0)
        $display("FAIL after_done done=%b valid=%b want 0 0", done, vld);
      else n_ok++;
    end
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_chk++;
    if (vld !== 0 || addr !== 0 || eot !== 0 || busy !== 0 ||
        done !== 0 || ovf !== 0 || dcnt !== 0)
      $display("FAIL reset_outputs v=%b a=%0d e=%b b=%b d=%b o=%b c=%0d want all 0",
               vld, addr, eot, busy, done, ovf, dcnt);
    else n_ok++;
    drops = '0;
`ifdef AER_TIMESTAMP_EN
    exp_ts = '0;
    n_chk++;
    if (ts !== 16'd0) $display("FAIL reset_ts got %0d want 0", ts);
    else n_ok++;
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    @(negedge clk);
    n_chk++;
    if (vld !== 0 || busy !== 0 || done !== 0 || dcnt !== 0)
      $display("FAIL idle_after_reset v=%b b=%b d=%b c=%0d want 0", vld, busy, done, dcnt);
    else n_ok++;
  endtask

  task automatic test_basic;
    logic [NN-1:0] sp;
    sp = '0; sp[3] = 1'b1; sp[17] = 1'b1; sp[253] = 1'b1;
    run_tick(sp, 100, 0, -1, 0, 1'b1, 1'b0, '0, 1'b0);
  endtask

  task automatic test_empty;
    run_tick('0, 100, 0, -1, 0, 1'b1, 1'b0, '0, 1'b0);
  endtask

  task automatic test_stall;
    logic [NN-1:0] sp;
    sp = '0; sp[0] = 1'b1; sp[1] = 1'b1;
    run_tick(sp, 100, 5, -1, 0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic test_overflow;
    run_tick('1, 100, 0, 10, 0, 1'b1, 1'b0, '0, 1'b0);
  endtask

  task automatic test_async_reset;
    logic [NN-1:0] sp;
    bit found;
    sp = '0; sp[3] = 1'b1; sp[17] = 1'b1; sp[253] = 1'b1;
    @(negedge clk);
    tick = 1'b1; spikes = sp; rdy = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (vld === 1'b1 && addr === 8'd17) found = 1'b1;
    end
    n_chk++;
    if (!found) $display("FAIL reach_addr17 got %b want 1", found);
    else n_ok++;
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if (vld !== 1'b0 || busy !== 1'b0 || eot !== 1'b0)
      $display("FAIL async_reset valid=%b busy=%b eot=%b want 0 0 0", vld, busy, eot);
    else n_ok++;
    drops = '0;
`ifdef AER_TIMESTAMP_EN
    exp_ts = '0;
`endif
    rdy = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    sp = '0; sp[5] = 1'b1;
    run_tick(sp, 100, 0, -1, 0, 1'b1, 1'b0, '0, 1'b0);
  endtask

  task automatic test_back_to_back;
    logic [NN-1:0] a, b;
    a = rnd_vec(3);
    b = rnd_vec(3);
    run_tick(a, 100, 0, -1, 0, 1'b1, 1'b1, b, 1'b0);
    run_tick(b, 100, 0, -1, 0, 1'b1, 1'b0, '0, 1'b1);
  endtask

  task automatic test_random;
    for (int it = 0; it < 20; it++) begin
      run_tick(rnd_vec($urandom_range(30)), 70, 0, -1, 5,
               1'b0, 1'b0, '0, 1'b0);
    end
  endtask

`ifdef AER_TIMESTAMP_EN
  task automatic test_timestamp;
    logic [NN-1:0] sp;
    do_reset();
    sp = '0; sp[7] = 1'b1;
    run_tick(sp, 100, 0, -1, 0, 1'b1, 1'b0, '0, 1'b0);
    run_tick(sp, 100, 0, 1, 0, 1'b0, 1'b0, '0, 1'b0);
    run_tick(sp, 100, 0, -1, 0, 1'b1, 1'b0, '0, 1'b0);
  endtask
`endif

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_basic();
    test_empty();
    test_stall();
    test_overflow();
    test_async_reset();
    test_back_to_back();
    test_random();
`ifdef AER_TIMESTAMP_EN
    test_timestamp();
`endif
    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

endmodule
